tmds_encoder: RTL and testbench
===============================

# tmds_encoder

Full per-channel TMDS encoder for the HDMI/DVI output path. Takes one 8-bit colour byte or 2-bit control word per pixel clock and produces a 10-bit DC-balanced TMDS symbol. It wraps the transition-minimising stage, tracks running disparity, and switches between video and control periods. One instance per colour channel, feeding the 10:1 serialiser.

## Interface
- No parameters. Widths are fixed by the TMDS standard.
- clk_in  input  1  pixel clock. Single clock domain.
- rst_in  input  1  synchronous, active-high reset.
- data_in  input  8  pixel byte, sampled when ve_in=1.
- control_in  input  2  {C1,C0} control bits, sampled when ve_in=0.
- ve_in  input  1  video enable: 1 = video period, 0 = control/blanking period.
- tmds_out  output  10  encoded symbol, registered. Bit 0 is transmitted first.

## Operation
- Stage 1, registered:
  - q_m[8:0] comes from the transition-minimisation stage.
  - If ones(data)>4, or ones(data)==4 and data[0]==0: XNOR chain, q_m[8]=0.
  - Otherwise: XOR chain, q_m[8]=1.
  - ve_in and control_in are registered alongside q_m.
- Stage 2, registered, when stage-1 ve=1. N1=ones(q_m[7:0]), N0=8−N1, tally is signed.
  - tally==0 or N1==N0:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - tally += q_m[8] ? (N1−N0) : (N0−N1).
  - (tally>0 and N1>N0) or (tally<0 and N0>N1):
    - out = {1, q_m[8], ~q_m[7:0]}.
    - tally += 2·q_m[8] + (N0−N1).
  - Otherwise:
    - out = {0, q_m[8], q_m[7:0]}.
    - tally += (N1−N0) − 2·(~q_m[8]).
- Stage 2 when stage-1 ve=0:
  - out = control code for the stage-1 control value: 00→10'b1101010100, 01→10'b0010101011, 10→10'b0101010100, 11→10'b1010101011.
  - tally is forced to 0.
- Tally arithmetic:
  - 5-bit signed two's complement.
  - Value stays within [−10,+10] for any legal input sequence. Saturation is not required.
  - N1−N0 is computed at 5 bits with sign extension. No truncation.
- Period transitions:
  - ve 0→1: the first video symbol is encoded with tally==0, so the first branch applies.
  - ve 1→0: a control code is emitted on the same pipeline slot, with no gap symbol.
- Modes (implicit state): VIDEO (ve=1, tally live) and CONTROL (ve=0, tally held at 0). Transitions follow stage-1 ve only.

## Timing
- Latency: exactly 2 clk_in cycles from input sample to tmds_out. Throughput: 1 symbol/cycle, no stalls, no handshake.
- Reset, synchronous:
  - All stage registers, tally and tmds_out go to 0. Stage-1 ve=0 and control=00.
- After rst_in deasserts:
  - 1st edge: tmds_out shows the stage-1 reset contents, i.e. 10'b1101010100.
  - Then the 2-cycle pipeline holds.
- Reset asserted mid-video:
  - In-flight symbols are discarded.
  - tally=0 on the cycle after the reset edge.
  - tmds_out=0 for the duration of reset.
- ve_in toggling every cycle is legal. Each symbol is encoded independently, with tally cleared on every control slot.
- data_in is ignored when ve_in=0; control_in is ignored when ve_in=1.

## Structure
- Package tmds_pkg holds:
  - The four control-code localparams (CTRL_00..CTRL_11).
  - TALLY_W=5 and typedef logic signed [TALLY_W-1:0] tally_t.
- Sub-module: tm_choice, instanced in stage 1 for the q_m computation. Disparity and mode logic stay inline.
- Ones-count: a combinational function in tmds_pkg.

## Test plan
- Reset, then ve=0 with control 00,01,10,11 on consecutive cycles → 10'b1101010100, 0010101011, 0101010100, 1010101011 appear 2 cycles later, in order. tally=0 throughout.
- ve=1, data 0x00 twice from tally 0 → 0x100 (tally −8), then 0x3FF (tally +2).
- ve=1, data 0xFF from tally 0 → 0x200, tally −8.
- Reset asserted mid-stream after tally=+2, then data 0x00 with ve=1 → tmds_out=0 during reset; first video symbol 0x100 from tally 0.
- Random 10k-symbol video stream against a behavioural model:
  - Outputs match bit-exact.
  - Tally stays within [−10,+10].
  - Cumulative disparity of the output stream stays within ±10.
- ve toggling every cycle with data 0xAA and control 01 → alternating video symbol (tally-0 branch every time) and 10'b0010101011.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared constants, types and helpers for the per-channel TMDS encoder.
package tmds_pkg;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    localparam int TALLY_W = 5;
    typedef logic signed [TALLY_W-1:0] tally_t;

    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/tmds_encoder_tm_choice.sv
// Transition-minimisation stage: picks the XOR or XNOR chain for an 8-bit byte.
module tm_choice
    import tmds_pkg::*;
(
    input  logic [7:0] data,
    output logic [8:0] q_m
);

    logic [3:0] n1;
    logic       use_xnor;
    logic [8:0] q;

    always_comb begin
        n1       = ones8(data);
        use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !data[0]);
        q        = '0;
        q[0]     = data[0];
        for (int i = 1; i < 8; i++) begin
            q[i] = use_xnor ? ~(q[i-1] ^ data[i]) : (q[i-1] ^ data[i]);
        end
        q[8]     = ~use_xnor;
        q_m      = q;
    end

endmodule

// File: rtl/tmds_encoder.sv
// Per-channel TMDS encoder: two registered stages, running disparity and
// video/control period switching.
module tmds_encoder
    import tmds_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] data_in,
    input  logic [1:0] control_in,
    input  logic       ve_in,
    output logic [9:0] tmds_out
);

    logic [8:0] q_m_c;
    logic [8:0] q_m_p1;
    logic       ve_p1;
    logic [1:0] ctrl_p1;

    tally_t     tally_p2;
    tally_t     tally_nxt;
    logic [9:0] sym_nxt;

    tally_t     n1;
    tally_t     n0;
    tally_t     diff;
    tally_t     two_q8;
    tally_t     two_nq8;
    logic       q8;
    logic [7:0] qm;

    tm_choice u_tm_choice (
        .data (data_in),
        .q_m  (q_m_c)
    );

    // Stage 1: transition-minimised word plus period/control side-band
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            q_m_p1  <= '0;
            ve_p1   <= 1'b0;
            ctrl_p1 <= 2'b00;
        end else begin
            q_m_p1  <= q_m_c;
            ve_p1   <= ve_in;
            ctrl_p1 <= control_in;
        end
    end

    always_comb begin
        q8        = q_m_p1[8];
        qm        = q_m_p1[7:0];
        n1        = tally_t'({1'b0, ones8(qm)});
        n0        = 5'sd8 - n1;
        diff      = n1 - n0;
        two_q8    = q8 ? 5'sd2 : 5'sd0;
        two_nq8   = q8 ? 5'sd0 : 5'sd2;
        sym_nxt   = '0;
        tally_nxt = '0;
        if (!ve_p1) begin
            // Control slots always restart the disparity count from zero
            case (ctrl_p1)
                2'b00:   sym_nxt = CTRL_00;
                2'b01:   sym_nxt = CTRL_01;
                2'b10:   sym_nxt = CTRL_10;
                default: sym_nxt = CTRL_11;
            endcase
            tally_nxt = '0;
        end else if ((tally_p2 == 5'sd0) || (n1 == n0)) begin
            sym_nxt   = {~q8, q8, (q8 ? qm : ~qm)};
            tally_nxt = q8 ? (tally_p2 + diff) : (tally_p2 - diff);
        end else if (((tally_p2 > 5'sd0) && (n1 > n0)) ||
                     ((tally_p2 < 5'sd0) && (n0 > n1))) begin
            sym_nxt   = {1'b1, q8, ~qm};
            tally_nxt = tally_p2 + two_q8 - diff;
        end else begin
            sym_nxt   = {1'b0, q8, qm};
            tally_nxt = tally_p2 + diff - two_nq8;
        end
    end

    // Stage 2: registered symbol and running disparity
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tmds_out <= '0;
            tally_p2 <= '0;
        end else begin
            tmds_out <= sym_nxt;
            tally_p2 <= tally_nxt;
        end
    end

endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboard bench for tmds_encoder: directed steps plus a long random video run.
module tb_tmds_encoder;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [7:0] data_in = '0;
    logic [1:0] control_in = '0;
    logic       ve_in = 1'b0;
    logic [9:0] tmds_out;

    tmds_encoder dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .data_in    (data_in),
        .control_in (control_in),
        .ve_in      (ve_in),
        .tmds_out   (tmds_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic [9:0] sym;
        int         tally;
        bit         track;
        string      tag;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   mtally = 0;
    int   cum = 0;
    int   max_cum = 0;
    int   max_tally = 0;

    // Reference encoder working directly from the TMDS encoding rules
    task automatic model(input logic ve, input logic [7:0] d, input logic [1:0] c,
                         output logic [9:0] s);
        int   cnt, n1, n0;
        bit   xn;
        logic [8:0] q;
        if (!ve) begin
            case (c)
                2'b00: s = 10'b1101010100;
                2'b01: s = 10'b0010101011;
                2'b10: s = 10'b0101010100;
                default: s = 10'b1010101011;
            endcase
            mtally = 0;
        end else begin
            cnt  = $countones(d);
            xn   = (cnt > 4) || (cnt == 4 && d[0] == 1'b0);
            q    = '0;
            q[0] = d[0];
            for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
            q[8] = !xn;
            n1   = $countones(q[7:0]);
            n0   = 8 - n1;
            if (mtally == 0 || n1 == n0) begin
                s = {~q[8], q[8], (q[8] ? q[7:0] : ~q[7:0])};
                mtally += q[8] ? (n1 - n0) : (n0 - n1);
            end else if ((mtally > 0 && n1 > n0) || (mtally < 0 && n0 > n1)) begin
                s = {1'b1, q[8], ~q[7:0]};
                mtally += 2 * int'(q[8]) + (n0 - n1);
            end else begin
                s = {1'b0, q[8], q[7:0]};
                mtally += (n1 - n0) - 2 * int'(!q[8]);
            end
        end
    endtask

    task automatic check_out(input exp_t e);
        int t;
        t = int'(dut.tally_p2);
        checks++;
        assert (tmds_out === e.sym) else begin
            errors++;
            $error("FAIL %s symbol: got %b expected %b", e.tag, tmds_out, e.sym);
        end
        checks++;
        assert (t === e.tally) else begin
            errors++;
            $error("FAIL %s tally: got %0d expected %0d", e.tag, t, e.tally);
        end
        if (e.track) begin
            cum += 2 * $countones(tmds_out) - 10;
            if ((cum < 0 ? -cum : cum) > max_cum) max_cum = (cum < 0 ? -cum : cum);
            if ((t < 0 ? -t : t) > max_tally) max_tally = (t < 0 ? -t : t);
        end
    endtask

    task automatic drive(input logic ve, input logic [7:0] d, input logic [1:0] c,
                         input bit use_k, input logic [9:0] k, input bit trk,
                         input string tag);
        logic [9:0] s;
        exp_t e;
        ve_in = ve;
        data_in = d;
        control_in = c;
        model(ve, d, c, s);
        e.sym = use_k ? k : s;
        e.tally = mtally;
        e.track = trk;
        e.tag = tag;
        sbq.push_back(e);
        @(posedge clk_in);
        #1;
        if (sbq.size() == 2) check_out(sbq.pop_front());
    endtask

    task automatic reset_for(input int n);
        exp_t e;
        int t;
        rst_in = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            #1;
            t = int'(dut.tally_p2);
            checks++;
            assert (tmds_out === 10'd0) else begin
                errors++;
                $error("FAIL reset_out: got %b expected 0", tmds_out);
            end
            checks++;
            assert (t === 0) else begin
                errors++;
                $error("FAIL reset_tally: got %0d expected 0", t);
            end
        end
        rst_in = 1'b0;
        sbq.delete();
        mtally = 0;
        e.sym = 10'b1101010100;
        e.tally = 0;
        e.track = 1'b0;
        e.tag = "post_reset";
        sbq.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_for(3);

        drive(1'b0, 8'h5A, 2'b00, 1, 10'b1101010100, 0, "ctrl00");
        drive(1'b0, 8'hC3, 2'b01, 1, 10'b0010101011, 0, "ctrl01");
        drive(1'b0, 8'h0F, 2'b10, 1, 10'b0101010100, 0, "ctrl10");
        drive(1'b0, 8'hF0, 2'b11, 1, 10'b1010101011, 0, "ctrl11");

        drive(1'b1, 8'h00, 2'b00, 1, 10'h100, 0, "vid00_first");
        drive(1'b1, 8'h00, 2'b00, 1, 10'h3FF, 0, "vid00_second");
        drive(1'b1, 8'h00, 2'b00, 0, 10'h000, 0, "vid00_inflight");
        reset_for(2);
        drive(1'b1, 8'h00, 2'b00, 1, 10'h100, 0, "vid00_after_reset");

        drive(1'b0, 8'h00, 2'b00, 1, 10'b1101010100, 0, "ctrl_gap");
        drive(1'b1, 8'hFF, 2'b00, 1, 10'h200, 0, "vidFF");

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 8'hAA, 2'($urandom_range(0, 3)), 1, 10'h233, 0, "toggle_vid");
            drive(1'b0, 8'($urandom_range(0, 255)), 2'b01, 1, 10'b0010101011, 0, "toggle_ctrl");
        end

        drive(1'b0, 8'h00, 2'b10, 0, 10'h000, 0, "pre_random");
        for (int i = 0; i < 10000; i++) begin
            drive(1'b1, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), 0, 10'h000, 1,
                  "random_vid");
        end
        drive(1'b0, 8'h00, 2'b11, 0, 10'h000, 0, "post_random");
        drive(1'b0, 8'h00, 2'b00, 0, 10'h000, 0, "flush");

        checks++;
        assert (max_tally <= 10) else begin
            errors++;
            $error("FAIL tally_range: got max |tally| %0d expected <= 10", max_tally);
        end
        checks++;
        assert (max_cum <= 10) else begin
            errors++;
            $error("FAIL cum_disparity: got max |disparity| %0d expected <= 10", max_cum);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
